// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: prescaled pixel/line counters with registered, zero-skew sync/enable decode.
// Optional macro VGA_TIMING_PIPE_EN adds one extra register stage on hsync/vsync only.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        enable,
  output logic        pix_tick,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_reg, presc_next;
  logic [11:0]   h_cnt_reg, h_cnt_next;
  logic [11:0]   v_cnt_reg, v_cnt_next;
  logic          hsync_reg, hsync_next;
  logic          vsync_reg, vsync_next;
  logic          enable_reg, enable_next;
  logic          pix_tick_reg;
  logic          frame_tick_reg, frame_tick_next;
  logic          advance, h_wrap, v_wrap;

  always_comb begin
    advance    = (presc_reg == PRESC_LAST);
    presc_next = advance ? '0 : presc_reg + PW'(1);
    h_wrap     = (h_cnt_reg == H_LAST);
    v_wrap     = (v_cnt_reg == V_LAST);
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (advance) begin
      if (h_wrap) begin
        h_cnt_next = '0;
        v_cnt_next = v_wrap ? '0 : v_cnt_reg + 12'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 12'd1;
      end
    end
    // Decode from the next counter values so the registered flags line up with the counters.
    hsync_next      = !(h_cnt_next < H_SYNC_END);
    vsync_next      = !(v_cnt_next < V_SYNC_END);
    enable_next     = (h_cnt_next >= H_ACT_START) && (h_cnt_next < H_ACT_END) &&
                      (v_cnt_next >= V_ACT_START) && (v_cnt_next < V_ACT_END);
    frame_tick_next = advance && h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg      <= '0;
      h_cnt_reg      <= H_LAST;
      v_cnt_reg      <= V_LAST;
      hsync_reg      <= 1'b1;
      vsync_reg      <= 1'b1;
      enable_reg     <= 1'b0;
      pix_tick_reg   <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      h_cnt_reg      <= h_cnt_next;
      v_cnt_reg      <= v_cnt_next;
      hsync_reg      <= hsync_next;
      vsync_reg      <= vsync_next;
      enable_reg     <= enable_next;
      pix_tick_reg   <= advance;
      frame_tick_reg <= frame_tick_next;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  // Extra sync stage to match a downstream registered RGB path.
  logic hsync_dly_reg, vsync_dly_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_dly_reg <= 1'b1;
      vsync_dly_reg <= 1'b1;
    end else begin
      hsync_dly_reg <= hsync_reg;
      vsync_dly_reg <= vsync_reg;
    end
  end

  assign hsync = hsync_dly_reg;
  assign vsync = vsync_dly_reg;
`else
  assign hsync = hsync_reg;
  assign vsync = vsync_reg;
`endif

  assign h_cnt      = h_cnt_reg;
  assign v_cnt      = v_cnt_reg;
  assign enable     = enable_reg;
  assign pix_tick   = pix_tick_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance plus two reduced-geometry instances.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_EN
  localparam int SYNC_LAT = 1;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default geometry, CLK_DIV=4
  logic [11:0] d_h, d_v;
  logic d_hs, d_vs, d_en, d_pt, d_ft;
  // small geometry 17x9, CLK_DIV=2
  logic [11:0] s_h, s_v;
  logic s_hs, s_vs, s_en, s_pt, s_ft;
  // small geometry 17x9, CLK_DIV=1
  logic [11:0] o_h, o_v;
  logic o_hs, o_vs, o_en, o_pt, o_ft;

  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n), .h_cnt(d_h), .v_cnt(d_v), .hsync(d_hs), .vsync(d_vs),
    .enable(d_en), .pix_tick(d_pt), .frame_tick(d_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .h_cnt(s_h), .v_cnt(s_v), .hsync(s_hs), .vsync(s_vs),
    .enable(s_en), .pix_tick(s_pt), .frame_tick(s_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1)
  ) dut_div1 (
    .clk(clk), .rst_n(rst_n), .h_cnt(o_h), .v_cnt(o_v), .hsync(o_hs), .vsync(o_vs),
    .enable(o_en), .pix_tick(o_pt), .frame_tick(o_ft)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %-18s observed %0d expected %0d", tag, obs, exp);
  endtask

  // statistics gathered over the run after reset release
  int d_ft_first, d_ft_cnt, d_ft_h, d_ft_v, d_hs_fall, d_hs_rise, d_hs_low, d_line2;
  int d_vs_rise, d_en_cnt;
  int s_ft_first, s_ft_second, s_ft_cnt, s_en_frame, s_en_first, s_en_first_h, s_en_first_v;
  int s_en_bad, s_ft_en, s_vs_low, s_pt_frame;
  int o_ft_first, o_ft_second, o_pt_zero, o_h_bad;
  logic d_hs_prev, d_vs_prev;
  logic [11:0] d_h_prev, o_h_prev, o_h_exp;
  int found, mr_first, mr_second, d_mr_first;

  initial begin
    d_ft_first = -1; d_ft_cnt = 0; d_ft_h = -1; d_ft_v = -1; d_hs_fall = -1; d_hs_rise = -1;
    d_hs_low = 0; d_line2 = -1; d_vs_rise = -1; d_en_cnt = 0;
    s_ft_first = -1; s_ft_second = -1; s_ft_cnt = 0; s_en_frame = 0; s_en_first = -1;
    s_en_first_h = -1; s_en_first_v = -1; s_en_bad = 0; s_ft_en = 0; s_vs_low = 0; s_pt_frame = 0;
    o_ft_first = -1; o_ft_second = -1; o_pt_zero = 0; o_h_bad = 0;

    // reset held for 5 clocks
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_d_h", 32'(d_h), 799);
    chk("rst_d_v", 32'(d_v), 524);
    chk("rst_d_hsync", 32'(d_hs), 1);
    chk("rst_d_vsync", 32'(d_vs), 1);
    chk("rst_d_enable", 32'(d_en), 0);
    chk("rst_d_pix_tick", 32'(d_pt), 0);
    chk("rst_d_frame_tick", 32'(d_ft), 0);
    chk("rst_s_h", 32'(s_h), 16);
    chk("rst_s_v", 32'(s_v), 8);

    // free run from release; n counts clock edges since release
    rst_n = 1'b1;
    d_hs_prev = d_hs; d_vs_prev = d_vs; d_h_prev = d_h; o_h_prev = o_h;
    for (int n = 1; n <= 6500; n++) begin
      @(negedge clk);
      // default instance
      if (d_ft) begin
        d_ft_cnt++;
        if (d_ft_first < 0) begin d_ft_first = n; d_ft_h = int'(d_h); d_ft_v = int'(d_v); end
      end
      if (n == 4 + SYNC_LAT + 1) chk("pipe_hsync_low", 32'(d_hs), 0);
      if (n == 4) chk("hsync_at_tick", 32'(d_hs), 32'(SYNC_LAT));
      if (d_hs_prev && !d_hs && d_hs_fall < 0) d_hs_fall = n;
      if (!d_hs_prev && d_hs && d_hs_rise < 0) d_hs_rise = n;
      if (!d_vs_prev && d_vs && d_vs_rise < 0) d_vs_rise = n;
      if (n >= 4 && n <= 3203 && !d_hs) d_hs_low++;
      if (n > 4 && d_h == 12'd0 && d_h_prev != 12'd0 && d_line2 < 0) d_line2 = n;
      if (d_en) d_en_cnt++;
      d_hs_prev = d_hs; d_vs_prev = d_vs; d_h_prev = d_h;
      // small instance
      if (s_ft) begin
        s_ft_cnt++;
        if (s_ft_first < 0) s_ft_first = n;
        else if (s_ft_second < 0) s_ft_second = n;
      end
      if (n >= 2 && n <= 307) begin
        if (s_en) s_en_frame++;
        if (!s_vs) s_vs_low++;
        if (s_pt) s_pt_frame++;
      end
      if (s_en && s_en_first < 0) begin
        s_en_first = n; s_en_first_h = int'(s_h); s_en_first_v = int'(s_v);
      end
      if (s_en && (s_v < 12'd4 || s_v >= 12'd8 || s_h < 12'd7 || s_h >= 12'd15)) s_en_bad++;
      if (s_en && s_ft) s_ft_en++;
      // CLK_DIV=1 instance
      if (o_ft) begin
        if (o_ft_first < 0) o_ft_first = n;
        else if (o_ft_second < 0) o_ft_second = n;
      end
      if (!o_pt) o_pt_zero++;
      o_h_exp = (o_h_prev == 12'd16) ? 12'd0 : o_h_prev + 12'd1;
      if (n >= 2 && o_h != o_h_exp) o_h_bad++;
      o_h_prev = o_h;
    end

    chk("d_first_ft_clk", 32'(d_ft_first), 4);
    chk("d_first_ft_h", 32'(d_ft_h), 0);
    chk("d_first_ft_v", 32'(d_ft_v), 0);
    chk("d_ft_count", 32'(d_ft_cnt), 1);
    chk("d_hsync_fall", 32'(d_hs_fall), 32'(4 + SYNC_LAT));
    chk("d_hsync_rise", 32'(d_hs_rise), 32'(388 + SYNC_LAT));
    chk("d_hsync_low_clks", 32'(d_hs_low), 384);
    chk("d_line_start2", 32'(d_line2), 3204);
    chk("d_vsync_rise", 32'(d_vs_rise), 32'(6404 + SYNC_LAT));
    chk("d_enable_vblank", 32'(d_en_cnt), 0);
    chk("s_first_ft_clk", 32'(s_ft_first), 2);
    chk("s_second_ft_clk", 32'(s_ft_second), 308);
    chk("s_ft_count", 32'(s_ft_cnt), 22);
    chk("s_enable_clks", 32'(s_en_frame), 64);
    chk("s_enable_first", 32'(s_en_first), 152);
    chk("s_enable_first_h", 32'(s_en_first_h), 7);
    chk("s_enable_first_v", 32'(s_en_first_v), 4);
    chk("s_enable_outside", 32'(s_en_bad), 0);
    chk("s_ft_with_enable", 32'(s_ft_en), 0);
    chk("s_vsync_low_clks", 32'(s_vs_low), 68);
    chk("s_pix_ticks", 32'(s_pt_frame), 153);
    chk("o_first_ft_clk", 32'(o_ft_first), 1);
    chk("o_second_ft_clk", 32'(o_ft_second), 154);
    chk("o_pix_tick_zero", 32'(o_pt_zero), 0);
    chk("o_h_step_err", 32'(o_h_bad), 0);

    // mid-frame reset at small (h=10, v=5)
    found = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      @(negedge clk);
      if (s_h == 12'd10 && s_v == 12'd5) found = 1;
    end
    chk("mr_position_found", 32'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_s_h", 32'(s_h), 16);
    chk("mr_s_v", 32'(s_v), 8);
    chk("mr_s_hsync", 32'(s_hs), 1);
    chk("mr_s_vsync", 32'(s_vs), 1);
    chk("mr_s_pix_tick", 32'(s_pt), 0);
    chk("mr_d_h", 32'(d_h), 799);
    rst_n = 1'b1;
    mr_first = -1; mr_second = -1; d_mr_first = -1;
    for (int n = 1; n <= 700 && mr_second < 0; n++) begin
      @(negedge clk);
      if (d_ft && d_mr_first < 0) d_mr_first = n;
      if (s_ft) begin
        if (mr_first < 0) mr_first = n;
        else mr_second = n;
      end
    end
    chk("mr_s_first_ft", 32'(mr_first), 2);
    chk("mr_s_frame_len", 32'(mr_second - mr_first), 306);
    chk("mr_d_first_ft", 32'(d_mr_first), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
